// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the pipeline hazard controller.
//   FWD_*       : E-stage operand source select codes
//   mem_state_e : dmem handshake FSM state encoding
package pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/perf_counter.sv
// perf_counter: saturating event counter.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc_i : count one event this cycle
//   cnt_o : current count, sticks at all-ones
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard / stall / flush controller for a 5-stage pipeline.
//   clk, rst               : clock, synchronous active-high reset
//   i_rs*_d, i_rs*_e       : source registers of the D and E instructions
//   i_rd_*, i_regwrite_*   : destination register / write enable per stage
//   i_load_e, i_br_taken   : E is a load / E resolved a taken branch
//   i_imem_valid           : fetch delivered an instruction
//   i_dmem_req/ready       : M-stage data memory handshake
//   o_fwd_a/b              : E operand source select
//   o_stall_*, o_flush_*   : hold a stage register / load a bubble
//   o_mem_busy             : dmem FSM is waiting
//   o_stall_cnt/flush_cnt  : fetch-stall cycles / branch-flush cycles
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_rs1_d,
  input  logic [REG_AW-1:0] i_rs2_d,
  input  logic [REG_AW-1:0] i_rs1_e,
  input  logic [REG_AW-1:0] i_rs2_e,
  input  logic [REG_AW-1:0] i_rd_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_e,
  input  logic              i_regwrite_m,
  input  logic              i_regwrite_w,
  input  logic              i_load_e,
  input  logic              i_br_taken,
  input  logic              i_imem_valid,
  input  logic              i_dmem_req,
  input  logic              i_dmem_ready,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_stall_e,
  output logic              o_stall_m,
  output logic              o_flush_d,
  output logic              o_flush_e,
  output logic              o_flush_w,
  output logic              o_mem_busy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  // Writer in a stage hits a D-stage source; x0 never hits.
  function automatic logic rd_hit(input logic [REG_AW-1:0] rd, input logic we,
                                  input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
    return we && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // M is the younger producer, so it is checked first.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m, input logic we_m,
                                         input logic [REG_AW-1:0] rd_w, input logic we_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (FWD_EN != 0) begin
      if (we_m && (rd_m != '0) && (rd_m == rs))      sel = FWD_M;
      else if (we_w && (rd_w != '0) && (rd_w == rs)) sel = FWD_W;
    end
    return sel;
  endfunction

  mem_state_e state_q, state_d;
  logic       br_pend_q, br_pend_d;
  logic       mem_stall, ld_use, raw_stall, hazard, br, br_flush;

  // ---- dmem handshake FSM ----
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: if (i_dmem_req && !i_dmem_ready) begin
              state_d   = WAIT;
              mem_stall = 1'b1;
            end
      WAIT: if (i_dmem_ready) state_d = IDLE;
            else              mem_stall = 1'b1;
    endcase
  end

  // A branch resolved while memory stalls the pipe is remembered so its
  // flush lands on the release cycle even if E's redirect is not re-presented.
  assign br        = i_br_taken | br_pend_q;
  assign br_pend_d = mem_stall & br;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
    end
  end

  // ---- data hazards ----
  assign ld_use    = rd_hit(i_rd_e, i_load_e, i_rs1_d, i_rs2_d);
  assign raw_stall = (FWD_EN == 0) &&
                     (rd_hit(i_rd_e, i_regwrite_e, i_rs1_d, i_rs2_d) ||
                      rd_hit(i_rd_m, i_regwrite_m, i_rs1_d, i_rs2_d) ||
                      rd_hit(i_rd_w, i_regwrite_w, i_rs1_d, i_rs2_d));
  assign hazard    = ld_use | raw_stall;

  // Priority: reset > mem stall > branch redirect > data hazard > fetch miss.
  assign o_stall_f = !rst && (mem_stall || (!br && (hazard || !i_imem_valid)));
  assign o_stall_d = !rst && (mem_stall || (!br && hazard));
  assign o_stall_e = !rst && mem_stall;
  assign o_stall_m = !rst && mem_stall;
  assign o_flush_w = rst || mem_stall;
  assign o_flush_e = rst || (!mem_stall && (br || hazard));
  // A held D (hazard) must not also be flushed by a fetch miss.
  assign o_flush_d = rst || (!mem_stall && (br || (!hazard && !i_imem_valid)));
  assign br_flush  = !rst && !mem_stall && br;

  assign o_fwd_a = rst ? FWD_RF : fwd_sel(i_rs1_e, i_rd_m, i_regwrite_m, i_rd_w, i_regwrite_w);
  assign o_fwd_b = rst ? FWD_RF : fwd_sel(i_rs2_e, i_rd_m, i_regwrite_m, i_rd_w, i_regwrite_w);

  assign o_mem_busy = (state_q == WAIT);

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc_i(o_stall_f), .cnt_o(o_stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc_i(br_flush), .cnt_o(o_flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: two controllers share stimulus -- index 0 with bypass and
// 32-bit counters, index 1 without bypass and 3-bit counters (saturation).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rw_e, rw_m, rw_w, load_e, br_taken, imem_valid, dmem_req, dmem_ready;

  logic [1:0] fwd_a [2], fwd_b [2];
  logic       stf [2], std [2], ste [2], stm [2], fld [2], fle [2], flw [2], busy [2];
  logic [31:0] scnt0, fcnt0;
  logic [2:0]  scnt1, fcnt1;

  int nvec = 0, nerr = 0;

  // reference model state
  bit     mb [2], pend [2];
  longint sc [2], fc [2];
  longint cmax [2];

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_rd_e(rd_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
    .i_regwrite_e(rw_e), .i_regwrite_m(rw_m), .i_regwrite_w(rw_w),
    .i_load_e(load_e), .i_br_taken(br_taken), .i_imem_valid(imem_valid),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_fwd_a(fwd_a[0]), .o_fwd_b(fwd_b[0]),
    .o_stall_f(stf[0]), .o_stall_d(std[0]), .o_stall_e(ste[0]), .o_stall_m(stm[0]),
    .o_flush_d(fld[0]), .o_flush_e(fle[0]), .o_flush_w(flw[0]),
    .o_mem_busy(busy[0]), .o_stall_cnt(scnt0), .o_flush_cnt(fcnt0)
  );

  pipe_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(3)) u_dut0 (
    .clk(clk), .rst(rst),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
    .i_rd_e(rd_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
    .i_regwrite_e(rw_e), .i_regwrite_m(rw_m), .i_regwrite_w(rw_w),
    .i_load_e(load_e), .i_br_taken(br_taken), .i_imem_valid(imem_valid),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_fwd_a(fwd_a[1]), .o_fwd_b(fwd_b[1]),
    .o_stall_f(stf[1]), .o_stall_d(std[1]), .o_stall_e(ste[1]), .o_stall_m(stm[1]),
    .o_flush_d(fld[1]), .o_flush_e(fle[1]), .o_flush_w(flw[1]),
    .o_mem_busy(busy[1]), .o_stall_cnt(scnt1), .o_flush_cnt(fcnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [4:0] rd, input logic we);
    return we && (rd != 0) && ((rd == rs1_d) || (rd == rs2_d));
  endfunction

  function automatic logic [1:0] fsel(input bit fen, input logic [4:0] rs);
    if (!fen || rst) return 2'b00;
    if (rw_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (rw_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  // Let combinational outputs settle, compare both DUTs with the model,
  // then advance the model to the state it will hold after the next edge.
  task automatic eval();
    bit fen, hz, ms, br, sf, sd, se, sm, fd, fe, fw;
    logic [1:0] ea, eb;
    #1;
    for (int k = 0; k < 2; k++) begin
      fen = (k == 0);
      ea  = fsel(fen, rs1_e);
      eb  = fsel(fen, rs2_e);
      hz  = (load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d)) ||
            (!fen && (hit(rd_e, rw_e) || hit(rd_m, rw_m) || hit(rd_w, rw_w)));
      ms  = !dmem_ready && (mb[k] || dmem_req);
      br  = br_taken || pend[k];
      {sf, sd, se, sm, fd, fe, fw} = '0;
      if (rst) begin
        fd = 1; fe = 1; fw = 1;
      end else if (ms) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end else if (br) begin
        fd = 1; fe = 1;
      end else if (hz) begin
        sf = 1; sd = 1; fe = 1;
      end else if (!imem_valid) begin
        sf = 1; fd = 1;
      end
      chk($sformatf("d%0d.fwd", k), {fwd_a[k], fwd_b[k]}, {ea, eb});
      chk($sformatf("d%0d.ctl", k),
          {stf[k], std[k], ste[k], stm[k], fld[k], fle[k], flw[k], busy[k]},
          {sf, sd, se, sm, fd, fe, fw, mb[k]});
      chk($sformatf("d%0d.stall_cnt", k), (k == 0) ? 64'(scnt0) : 64'(scnt1), sc[k]);
      chk($sformatf("d%0d.flush_cnt", k), (k == 0) ? 64'(fcnt0) : 64'(fcnt1), fc[k]);
      if (rst) begin
        mb[k] = 0; pend[k] = 0; sc[k] = 0; fc[k] = 0;
      end else begin
        mb[k]   = mb[k] ? !dmem_ready : (dmem_req && !dmem_ready);
        pend[k] = ms && br;
        if (sf)        sc[k] = sat_inc(sc[k], cmax[k]);
        if (!ms && br) fc[k] = sat_inc(fc[k], cmax[k]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    eval();
    tick();
  endtask

  task automatic clr();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {rw_e, rw_m, rw_w, load_e, br_taken, dmem_req, dmem_ready} = '0;
    imem_valid = 1'b1;
  endtask

  initial begin
    longint s0, f0;
    cmax[0] = (64'd1 << 32) - 1;
    cmax[1] = 7;
    clr();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mb = '{0, 0}; pend = '{0, 0}; sc = '{0, 0}; fc = '{0, 0};

    // reset state
    eval();
    chk("rst.flush", {fld[0], fle[0], flw[0], stf[0]}, 4'b1110);
    tick();
    rst = 1'b0;

    // bypass select: M beats W, then W, then x0 never matches
    rd_m = 5; rw_m = 1; rd_w = 5; rw_w = 1; rs1_e = 5;
    eval(); chk("fwd.m", fwd_a[0], 2'b10); chk("fwd.nobypass", fwd_a[1], 2'b00); tick();
    rw_m = 0;
    eval(); chk("fwd.w", fwd_a[0], 2'b01); tick();
    rd_m = 0; rd_w = 0; rw_m = 1; rs1_e = 0;
    eval(); chk("fwd.x0", fwd_a[0], 2'b00); tick();

    // load-use: one stall cycle, counter +1
    clr(); load_e = 1; rd_e = 3; rs2_d = 3; s0 = sc[0];
    eval(); chk("lu.stall", {stf[0], std[0], fle[0]}, 3'b111); tick();
    clr();
    eval(); chk("lu.cnt", scnt0, s0 + 1); chk("lu.release", stf[0], 1'b0); tick();

    // dmem: 3 wait cycles then ready
    dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      eval(); chk("mem.stall", {stf[0], std[0], ste[0], stm[0], flw[0]}, 5'b11111);
      chk("mem.busy", busy[0], (i != 0)); tick();
    end
    dmem_ready = 1;
    eval(); chk("mem.release", {stf[0], std[0], ste[0], stm[0], flw[0], busy[0]}, 6'b000001); tick();
    clr(); cyc();

    // branch held off by a 2-cycle mem stall, applied on release
    dmem_req = 1; br_taken = 1; f0 = fc[0];
    for (int i = 0; i < 2; i++) begin
      eval(); chk("brmem.hold", {fld[0], fle[0]}, 2'b00); tick();
    end
    dmem_ready = 1;
    eval(); chk("brmem.flush", {fld[0], fle[0], stf[0]}, 3'b110); tick();
    clr();
    eval(); chk("brmem.cnt", fcnt0, f0 + 1); tick();

    // no-bypass RAW stall
    rs1_d = 7; rd_m = 7; rw_m = 1;
    eval(); chk("raw.nofwd", {fwd_a[1], stf[1], std[1], fle[1]}, 5'b00111);
    chk("raw.fwd", stf[0], 1'b0); tick();

    // hazard + fetch miss: hold D, don't flush it
    clr(); load_e = 1; rd_e = 4; rs1_d = 4; imem_valid = 0;
    eval(); chk("lu.imem", {std[0], fld[0]}, 2'b10); tick();

    // branch vs fetch miss: redirect wins
    clr(); br_taken = 1; imem_valid = 0;
    eval(); chk("br.imem", stf[0], 1'b0); tick();

    // reset while WAIT, ready low
    clr(); dmem_req = 1; cyc();
    rst = 1;
    eval(); chk("rstwait.flush", {fld[0], fle[0], flw[0]}, 3'b111); tick();
    rst = 0; dmem_req = 0;
    eval(); chk("rstwait.state", {busy[0], busy[1]}, 2'b00);
    chk("rstwait.cnt", {scnt0, fcnt0}, 64'd0); tick();

    // fetch starvation saturates the 3-bit counter
    clr(); imem_valid = 0;
    for (int i = 0; i < 10; i++) cyc();
    eval(); chk("sat.cnt", scnt1, 3'd7); tick();

    // random traffic, small register space for frequent matches
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      rs1_d      = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e      = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e       = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
      rd_w       = 5'($urandom_range(0, 3));
      rw_e       = 1'($urandom); rw_m = 1'($urandom); rw_w = 1'($urandom);
      load_e     = ($urandom_range(0, 3) == 0);
      br_taken   = ($urandom_range(0, 5) == 0);
      imem_valid = ($urandom_range(0, 7) != 0);
      dmem_req   = ($urandom_range(0, 2) == 0);
      dmem_ready = 1'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter FWD_EN, default 1; 1 = EX bypass enabled, 0 = no bypass, RAW resolved by stalling.
REQ-003 SHALL have parameter CNT_W, default 32, perf-counter width.
REQ-004 SHALL have the ports below; one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- i_rs1_d, i_rs2_d  in  REG_AW  source registers of the instruction in D
- i_rs1_e, i_rs2_e  in  REG_AW  source registers of the instruction in E
- i_rd_e, i_rd_m, i_rd_w  in  REG_AW  destination registers in E/M/W
- i_regwrite_e, i_regwrite_m, i_regwrite_w  in  1  writeback enables per stage
- i_load_e  in  1  E instruction is a load
- i_br_taken  in  1  branch/jump resolved taken in E
- i_imem_valid  in  1  fetched instruction valid this cycle
- i_dmem_req  in  1  M instruction accesses dmem
- i_dmem_ready  in  1  dmem completes the access this cycle
- o_fwd_a, o_fwd_b  out  2  E operand select: 00 RF, 01 W result, 10 M ALU result
- o_stall_f, o_stall_d, o_stall_e, o_stall_m  out  1  hold the stage register
- o_flush_d, o_flush_e, o_flush_w  out  1  load a bubble into D/E/W
- o_mem_busy  out  1  dmem FSM in WAIT
- o_stall_cnt, o_flush_cnt  out  CNT_W  perf counters

Function
REQ-005 Register x0 SHALL never match: no forward, no stall, when the destination register is 0.
REQ-006 FWD_EN=1: o_fwd_x=10 when i_regwrite_m and i_rd_m==rs_e; else 01 when i_regwrite_w and i_rd_w==rs_e; else 00. M SHALL win over W.
REQ-007 FWD_EN=0: o_fwd_x SHALL be constant 00; any D source matching a writing E/M/W rd SHALL stall F,D and flush E (raw_stall).
REQ-008 Load-use: i_load_e, i_rd_e!=0 and i_rd_e equal to i_rs1_d or i_rs2_d SHALL stall F,D and flush E for exactly one cycle.
REQ-009 Branch: i_br_taken SHALL flush D and E in the same cycle and deassert o_stall_f; branch SHALL override load-use/raw stalls.
REQ-010 Dmem FSM, states IDLE/WAIT. IDLE->WAIT on i_dmem_req & !i_dmem_ready. WAIT->IDLE on i_dmem_ready. req & ready in IDLE SHALL cause no stall.
REQ-011 mem_stall = (IDLE & req & !ready) | (WAIT & !ready). It SHALL stall F,D,E,M and flush W, combinationally in the same cycle.
REQ-012 mem_stall SHALL take priority over everything else:
- o_flush_d/o_flush_e held 0 while mem_stall.
- A pending i_br_taken flush applies in the first non-stalled cycle.
REQ-013 Imem: !i_imem_valid without other stall SHALL stall F and flush D; with i_br_taken, redirect SHALL win (o_stall_f=0).
REQ-014 When load-use/raw stall and !i_imem_valid coincide, D SHALL be held (o_stall_d=1, o_flush_d=0).
REQ-015 Stall/flush/fwd outputs SHALL be combinational from inputs and FSM state (zero latency); o_mem_busy registered (state==WAIT).
REQ-016 o_stall_cnt SHALL increment each cycle o_stall_f=1, saturating at 2^CNT_W-1.
REQ-017 o_flush_cnt SHALL increment each cycle o_flush_e=1 due to i_br_taken, saturating at 2^CNT_W-1.

Reset
REQ-018 While rst=1:
- stalls 0, o_flush_d/e/w 1, o_fwd_x 00.
- FSM -> IDLE at the edge; counters -> 0 at the edge; o_mem_busy 0 after the edge.
REQ-019 rst in WAIT SHALL return to IDLE on that edge regardless of i_dmem_ready.

Structure
REQ-020 Shared package pipe_pkg SHALL hold FWD_RF=00, FWD_W=01, FWD_M=10 and the FSM state encoding (IDLE=0, WAIT=1).
REQ-021 One sub-module perf_counter (CNT_W, inc, saturating, sync reset) SHALL be instantiated twice.

Verification
REQ-022 rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1, rs1_e=5 -> o_fwd_a=10; clear regwrite_m -> 01; rd=0 -> 00.
REQ-023 Load in E with rd_e=3, rs2_d=3 -> stall_f=stall_d=flush_e=1 for one cycle; o_stall_cnt +1.
REQ-024 req=1, ready=0 for 3 cycles then 1:
- stall_f/d/e/m=1 and flush_w=1 for 3 cycles; o_mem_busy=1 cycles 2-4.
- All clear on the ready cycle.
REQ-025 br_taken during a 2-cycle mem stall -> flush_d/e=0 during the stall, 1 on the release cycle; o_flush_cnt +1.
REQ-026 FWD_EN=0, rs1_d=7, rd_m=7, regwrite_m=1 -> o_fwd_a=00, stall_f/d=1, flush_e=1.
REQ-027 Assert rst in WAIT with ready=0:
- Next cycle: FSM IDLE, counters 0, o_mem_busy 0.
- During rst: flush_d/e/w=1.
